// File: rtl/param_register_file.sv
// Parametrised 2-read/1-write register file with byte enables,
// optional write bypass, optional hardwired-zero entry and soft clear.
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rs_addr,
    input  logic [ADDR_W-1:0]     rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic                  rd_we,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W/8-1:0]   rd_be,
    input  logic [DATA_W-1:0]     rd_w_data,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_wr_merged;
    logic                w_zero_wr;
    logic                w_wr_acc;
    logic                w_rs_fwd;
    logic                w_rt_fwd;
    logic                w_rs_zero;
    logic                w_rt_zero;

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < NB; k++) begin
            w_mask[8*k +: 8] = {8{rd_be[k]}};
        end
    end

    assign w_zero_wr   = ZERO_REG && (rd_addr == '0);
    assign w_wr_acc    = rd_we && (r_state == ST_IDLE) && !w_zero_wr;
    assign w_wr_merged = (r_mem[rd_addr] & ~w_mask) | (rd_w_data & w_mask);

    // Clear sequencer: one entry per cycle, pointer wraps back to 0.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // A write coinciding with clr_req still commits: state is IDLE here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[rd_addr] <= w_wr_merged;
        end
    end

    function automatic logic [DATA_W-1:0] rd_mux(
        input logic              rst_n,
        input logic              zero,
        input logic              fwd,
        input logic [DATA_W-1:0] stored,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] mask
    );
        logic [DATA_W-1:0] v;
        v = zero ? '0 : stored;
        if (fwd) begin
            v = (v & ~mask) | (wdata & mask);
        end
        if (!rst_n) begin
            v = '0;
        end
        return v;
    endfunction

    assign w_rs_zero = ZERO_REG && (rs_addr == '0);
    assign w_rt_zero = ZERO_REG && (rt_addr == '0);
    assign w_rs_fwd  = BYPASS && w_wr_acc && (rd_addr == rs_addr);
    assign w_rt_fwd  = BYPASS && w_wr_acc && (rd_addr == rt_addr);

    assign rs_data = rd_mux(rst, w_rs_zero, w_rs_fwd, r_mem[rs_addr],
                            rd_w_data, w_mask);
    assign rt_data = rd_mux(rst, w_rt_zero, w_rt_fwd, r_mem[rt_addr],
                            rd_w_data, w_mask);

    assign busy = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: a default instance (32x32, zero reg,
// bypass) and a 64-bit x 8 instance without zero reg or bypass.
`timescale 1ns/1ps
module tb_param_register_file;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  a_rs = '0, a_rt = '0, a_wa = '0;
    logic [31:0] a_rsd, a_rtd, a_wd = '0;
    logic [3:0]  a_be = '0;
    logic        a_we = 1'b0, a_clr = 1'b0, a_busy;

    logic [2:0]  b_rs = '0, b_rt = '0, b_wa = '0;
    logic [63:0] b_rsd, b_rtd, b_wd = '0;
    logic [7:0]  b_be = '0;
    logic        b_we = 1'b0, b_clr = 1'b0, b_busy;

    param_register_file dut_a (
        .clk(clk), .rst(rst),
        .rs_addr(a_rs), .rt_addr(a_rt),
        .rs_data(a_rsd), .rt_data(a_rtd),
        .rd_we(a_we), .rd_addr(a_wa), .rd_be(a_be),
        .rd_w_data(a_wd), .clr_req(a_clr), .busy(a_busy)
    );

    param_register_file #(
        .DATA_W(64), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .rs_addr(b_rs), .rt_addr(b_rt),
        .rs_data(b_rsd), .rt_data(b_rtd),
        .rd_we(b_we), .rd_addr(b_wa), .rd_be(b_be),
        .rd_w_data(b_wd), .clr_req(b_clr), .busy(b_busy)
    );

    logic [31:0] ma [32];
    logic [63:0] mb [8];
    int a_left = 0;
    int b_left = 0;
    int checks = 0;
    int failures = 0;

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] v;
        v = old;
        for (int k = 0; k < 8; k++) if (be[k]) v[8*k +: 8] = nw[8*k +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp_a(input logic [4:0] ad);
        logic [31:0] v;
        if (!rst) return 32'h0;
        v = (ad == 5'd0) ? 32'h0 : ma[ad];
        if (a_we && a_left == 0 && a_wa != 5'd0 && a_wa == ad)
            v = 32'(merge({32'h0, v}, {32'h0, a_wd}, {4'h0, a_be}));
        return v;
    endfunction

    function automatic logic [63:0] exp_b(input logic [2:0] ad);
        if (!rst) return 64'h0;
        return mb[ad];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        #1;
        check({tag, ".a_rs"}, 64'(a_rsd), 64'(exp_a(a_rs)));
        check({tag, ".a_rt"}, 64'(a_rtd), 64'(exp_a(a_rt)));
        check({tag, ".a_busy"}, 64'(a_busy), 64'(a_left > 0));
        check({tag, ".b_rs"}, b_rsd, exp_b(b_rs));
        check({tag, ".b_rt"}, b_rtd, exp_b(b_rt));
        check({tag, ".b_busy"}, 64'(b_busy), 64'(b_left > 0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ma[i] = '0;
        for (int i = 0; i < 8; i++) mb[i] = '0;
        a_left = 0;
        b_left = 0;
    endtask

    // Apply the rules for the coming edge, then advance to just past it.
    task automatic tick();
        if (rst) begin
            if (a_left > 0) begin
                ma[32 - a_left] = '0;
                a_left--;
            end else begin
                if (a_we && a_wa != 5'd0)
                    ma[a_wa] = 32'(merge({32'h0, ma[a_wa]}, {32'h0, a_wd},
                                         {4'h0, a_be}));
                if (a_clr) a_left = 32;
            end
            if (b_left > 0) begin
                mb[8 - b_left] = '0;
                b_left--;
            end else begin
                if (b_we) mb[b_wa] = merge(mb[b_wa], b_wd, b_be);
                if (b_clr) b_left = 8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        model_reset();
        #1 rst = 1'b0;
        chk_all("rst_hold");
        #1 rst = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            a_rs = 5'(i); a_rt = 5'(31 - i); b_rs = 3'(i); b_rt = 3'(7 - i);
            chk_all("rst_read");
            tick();
        end

        // write/read sweep on both instances
        for (int i = 0; i < 32; i++) begin
            a_we = 1'b1; a_wa = 5'(i); a_wd = 32'(i); a_be = 4'hF;
            a_rs = 5'(i); a_rt = 5'(i - 1);
            b_we = (i < 8); b_wa = 3'(i); b_wd = 64'(i); b_be = 8'hFF;
            b_rs = 3'(i); b_rt = 3'(i - 1);
            chk_all("sweep_wr");
            tick();
        end
        a_we = 1'b0; b_we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a_rs = 5'(i); a_rt = 5'(i); b_rs = 3'(i); b_rt = 3'(i);
            chk_all("sweep_rd");
            check("sweep_a_val", 64'(a_rsd), 64'(i));
        end

        // zero entry: writes ignored on A, stored on B
        a_we = 1'b1; a_wa = 5'd0; a_wd = 32'hFFFF_FFFF; a_be = 4'hF;
        b_we = 1'b1; b_wa = 3'd0; b_wd = 64'h0123_4567_89AB_CDEF; b_be = 8'hFF;
        a_rs = 5'd0; b_rs = 3'd0;
        chk_all("zero_wr");
        tick();
        a_we = 1'b0; b_we = 1'b0;
        chk_all("zero_rd");
        check("zero_a", 64'(a_rsd), 64'h0);
        check("zero_b", b_rsd, 64'h0123_4567_89AB_CDEF);

        // byte enables
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hAABB_CCDD; a_be = 4'hF;
        chk_all("be_1");
        tick();
        a_wd = 32'h1122_3344; a_be = 4'b0101; a_rs = 5'd5;
        chk_all("be_2");
        tick();
        a_we = 1'b0;
        chk_all("be_rd");
        check("be_val", 64'(a_rsd), 64'hAA22_CC44);

        // bypass vs no bypass
        a_we = 1'b1; a_wa = 5'd7; a_wd = 32'hDEAD_BEEF; a_be = 4'hF; a_rs = 5'd7;
        b_we = 1'b1; b_wa = 3'd7; b_wd = 64'hDEAD_BEEF; b_be = 8'hFF; b_rs = 3'd7;
        chk_all("byp_same");
        check("byp_a_same", 64'(a_rsd), 64'hDEAD_BEEF);
        check("byp_b_old", b_rsd, 64'd7);
        tick();
        a_we = 1'b0; b_we = 1'b0;
        chk_all("byp_next");
        check("byp_b_next", b_rsd, 64'hDEAD_BEEF);

        // random traffic
        for (int c = 0; c < 300; c++) begin
            a_we = 1'($urandom); a_wa = 5'($urandom); a_wd = $urandom;
            a_be = 4'($urandom); a_rs = 5'($urandom); a_rt = 5'($urandom);
            if ($urandom_range(3) == 0) a_rs = a_wa;
            a_clr = ($urandom_range(99) == 0);
            b_we = 1'($urandom); b_wa = 3'($urandom);
            b_wd = {$urandom, $urandom}; b_be = 8'($urandom);
            b_rs = 3'($urandom); b_rt = 3'($urandom);
            b_clr = ($urandom_range(49) == 0);
            chk_all("rand");
            tick();
        end
        a_we = 1'b0; a_clr = 1'b0; b_we = 1'b0; b_clr = 1'b0;
        n = 0;
        while ((a_busy || b_busy) && n < 100) begin
            chk_all("rand_drain");
            tick();
            n++;
        end
        check("rand_drain_done", 64'(a_busy | b_busy), 64'h0);

        // soft clear on A
        for (int i = 0; i < 32; i++) begin
            a_we = 1'b1; a_wa = 5'(i); a_wd = $urandom | 32'h1; a_be = 4'hF;
            chk_all("fill_a");
            tick();
        end
        a_we = 1'b0; a_clr = 1'b1; a_rs = 5'd10; a_rt = 5'd20;
        chk_all("clr_req");
        tick();
        a_clr = 1'b0;
        n = 0;
        while (a_busy === 1'b1 && n < 100) begin
            a_we = (n == 30); a_wa = 5'd3; a_wd = 32'h5555_AAAA; a_be = 4'hF;
            chk_all("clr_run");
            if (n == 11) begin
                check("clr_e10_zero", 64'(a_rsd), 64'h0);
                check("clr_e20_live", 64'(a_rtd != 32'h0), 64'h1);
            end
            tick();
            n++;
        end
        a_we = 1'b0;
        check("clr_busy_len", 64'(n), 64'd32);
        for (int i = 0; i < 32; i++) begin
            a_rs = 5'(i); a_rt = 5'd3;
            chk_all("clr_after");
            check("clr_zero", 64'(a_rsd), 64'h0);
        end

        // write and clr_req in the same cycle
        a_we = 1'b1; a_wa = 5'd12; a_wd = 32'h1234_5678; a_be = 4'hF;
        a_clr = 1'b1; a_rs = 5'd12;
        chk_all("wrclr");
        tick();
        a_we = 1'b0; a_clr = 1'b0;
        n = 0;
        while (a_busy === 1'b1 && n < 100) begin
            chk_all("wrclr_run");
            tick();
            n++;
        end
        chk_all("wrclr_done");
        check("wrclr_len", 64'(n), 64'd32);
        check("wrclr_zero", 64'(a_rsd), 64'h0);

        // reset in the middle of a sweep
        for (int i = 1; i < 32; i += 3) begin
            a_we = 1'b1; a_wa = 5'(i); a_wd = $urandom | 32'h1; a_be = 4'hF;
            chk_all("fill_r");
            tick();
        end
        a_we = 1'b0; a_clr = 1'b1;
        tick();
        a_clr = 1'b0; a_rs = 5'd31; a_rt = 5'd28;
        for (int i = 0; i < 15; i++) begin
            chk_all("rclr_run");
            tick();
        end
        check("rclr_busy_pre", 64'(a_busy), 64'h1);
        #1 rst = 1'b0;
        model_reset();
        chk_all("rclr_async");
        check("rclr_busy", 64'(a_busy), 64'h0);
        check("rclr_rs", 64'(a_rsd), 64'h0);
        tick();
        rst = 1'b1;
        a_we = 1'b1; a_wa = 5'd9; a_wd = 32'hCAFE_F00D; a_be = 4'hF; a_rs = 5'd9;
        chk_all("rrel_wr");
        tick();
        a_we = 1'b0;
        chk_all("rrel_rd");
        check("rrel_val", 64'(a_rsd), 64'hCAFE_F00D);
        for (int i = 0; i < 32; i++) begin
            a_rs = 5'(i); a_rt = 5'(i);
            chk_all("rrel_all");
        end

        // soft clear on B
        for (int i = 0; i < 8; i++) begin
            b_we = 1'b1; b_wa = 3'(i); b_wd = {$urandom, $urandom | 32'h1};
            b_be = 8'hFF;
            chk_all("fill_b");
            tick();
        end
        b_we = 1'b0; b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        n = 0;
        while (b_busy === 1'b1 && n < 100) begin
            b_rs = 3'(n); b_rt = 3'(7 - n);
            chk_all("bclr_run");
            tick();
            n++;
        end
        check("bclr_len", 64'(n), 64'd8);
        for (int i = 0; i < 8; i++) begin
            b_rs = 3'(i); b_rt = 3'(i);
            chk_all("bclr_after");
            check("bclr_zero", b_rsd, 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
